sig_misr_checker: RTL and testbench

- Downstream consumer of a gated-register test datapath. Samples the 32-bit result each clock into a 64-bit MISR signature.
- Ignores a programmable warm-up window after start, then accumulates a fixed number of samples.
- Compares the final signature against an expected value and reports pass/fail.
- Replaces the ad-hoc sum/cycle-counter logic in self-checking benches with one reusable stage.

---
 rtl/sig_misr_checker_if.sv | 27 ++
 rtl/sig_misr_checker.sv | 89 ++++++++
 tb/tb_sig_misr_checker.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sig_misr_checker_if.sv
// Bus bundle for the MISR signature checker.
// The datapath side is the master, the checker is the slave.
interface sig_misr_checker_if #(
   parameter int DATA_W = 32,
   parameter int SIG_W  = 64,
   parameter int CNT_W  = 16
);
   logic              start;
   logic              data_valid;
   logic [DATA_W-1:0] data;
   logic [SIG_W-1:0]  expected_sig;
   logic              busy;
   logic              done;
   logic              pass;
   logic [SIG_W-1:0]  signature;
   logic [CNT_W-1:0]  sample_count;

   modport master (
      output start, data_valid, data, expected_sig,
      input  busy, done, pass, signature, sample_count
   );

   modport slave (
      input  start, data_valid, data, expected_sig,
      output busy, done, pass, signature, sample_count
   );
endinterface

// File: rtl/sig_misr_checker.sv
// Folds a result stream into a MISR signature after a warm-up
// window and compares it against a golden value.
module sig_misr_checker #(
   parameter int DATA_W        = 32,
   parameter int SIG_W         = 64,
   parameter int WARMUP_CYCLES = 10,
   parameter int ACCUM_SAMPLES = 80,
   parameter int CNT_W         = 16
) (
   input logic             clk,
   input logic             reset,
   sig_misr_checker_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE, WARMUP, ACCUM, DONE
   } state_t;

   localparam int WL = (WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WL);
   localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ACCUM_SAMPLES - 1);

   state_t           state;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [SIG_W-1:0] sig_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] warm_q;
   logic             fb;
   logic [SIG_W-1:0] next_sig;

   always_comb begin
      fb       = sig_q[SIG_W-1] ^ sig_q[2] ^ sig_q[0];
      next_sig = SIG_W'(bus.data) ^ {sig_q[SIG_W-2:0], fb};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         sig_q  <= '0;
         cnt_q  <= '0;
         warm_q <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  sig_q  <= '0;
                  cnt_q  <= '0;
                  warm_q <= '0;
                  pass_q <= 1'b0;
                  done_q <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= (WARMUP_CYCLES == 0) ? ACCUM : WARMUP;
               end
            end
            WARMUP: begin
               if (warm_q == W_LAST) begin
                  state <= ACCUM;
               end else begin
                  warm_q <= warm_q + 1'b1;
               end
            end
            ACCUM: begin
               if (bus.data_valid) begin
                  sig_q <= next_sig;
                  cnt_q <= cnt_q + 1'b1;
                  // last sample: finish and grade on the same edge
                  if (cnt_q == A_LAST) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     pass_q <= (next_sig == bus.expected_sig);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.pass         = pass_q;
   assign bus.signature    = sig_q;
   assign bus.sample_count = cnt_q;
endmodule

// File: tb/tb_sig_misr_checker.sv
// Directed and random checks of sig_misr_checker against a
// cycle-level behavioural model (WARMUP_CYCLES=2, ACCUM_SAMPLES=3).
module tb_sig_misr_checker;
   localparam int W = 2;
   localparam int A = 3;
   localparam logic [63:0] TAPS = 64'h8000_0000_0000_0005;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // model state
   bit          m_active;
   int          m_warm;
   int          m_cnt;
   logic [63:0] m_sig;
   bit          m_done;
   bit          m_pass;

   sig_misr_checker_if #(.DATA_W(32), .SIG_W(64), .CNT_W(16)) bus ();

   sig_misr_checker #(
      .DATA_W(32), .SIG_W(64), .WARMUP_CYCLES(W),
      .ACCUM_SAMPLES(A), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] misr(logic [63:0] s, logic [31:0] d);
      logic [63:0] shifted;
      shifted = (s << 1) | 64'(^(s & TAPS));
      return shifted ^ {32'h0, d};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(bit r, bit s, bit v, logic [31:0] d,
                             logic [63:0] e);
      if (r) begin
         m_active = 0; m_warm = 0; m_cnt = 0;
         m_sig = '0; m_done = 0; m_pass = 0;
      end else if (!m_active && s) begin
         m_active = 1; m_warm = W; m_cnt = 0;
         m_sig = '0; m_done = 0; m_pass = 0;
      end else if (m_active) begin
         if (m_warm > 0) begin
            m_warm--;
         end else if (v) begin
            m_sig = misr(m_sig, d);
            m_cnt++;
            if (m_cnt == A) begin
               m_active = 0;
               m_done = 1;
               m_pass = (m_sig == e);
            end
         end
      end
   endtask

   // one clock: drive, edge, model, compare everything
   task automatic cyc(bit r, bit s, bit v, logic [31:0] d,
                      logic [63:0] e);
      reset = r;
      bus.start = s;
      bus.data_valid = v;
      bus.data = d;
      bus.expected_sig = e;
      @(posedge clk);
      model_edge(r, s, v, d, e);
      #1;
      chk("busy", 64'(bus.busy), 64'(m_active));
      chk("done", 64'(bus.done), 64'(m_done));
      chk("pass", 64'(bus.pass), 64'(m_pass));
      chk("signature", bus.signature, m_sig);
      chk("sample_count", 64'(bus.sample_count), 64'(m_cnt));
      chk("busy_and_done", 64'(bus.busy & bus.done), 64'd0);
   endtask

   task automatic basic_run(logic [63:0] e);
      cyc(0, 1, 0, 32'h0, e);
      chk("start_busy", 64'(bus.busy), 64'd1);
      cyc(0, 0, 1, 32'hFFFF_FFFF, e);
      cyc(0, 0, 1, 32'hFFFF_FFFF, e);
      chk("warmup_mask", bus.signature, 64'h0);
      cyc(0, 0, 1, 32'h5, e);
      chk("sig_s1", bus.signature, 64'h5);
      cyc(0, 0, 1, 32'hA, e);
      chk("sig_s2", bus.signature, 64'h0);
      chk("not_done_yet", 64'(bus.done), 64'd0);
      cyc(0, 0, 1, 32'hF, e);
      chk("sig_s3", bus.signature, 64'hF);
      chk("done_edge6", 64'(bus.done), 64'd1);
   endtask

   initial begin
      logic [31:0] d;
      logic [63:0] e;
      bus.start = 0;
      bus.data_valid = 0;
      bus.data = '0;
      bus.expected_sig = '0;

      cyc(1, 1, 1, 32'h1234, 64'h0);
      cyc(1, 0, 0, 32'h0, 64'h0);
      chk("reset_sig", bus.signature, 64'h0);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      cyc(0, 0, 0, 32'h0, 64'h0);

      basic_run(64'hF);
      chk("basic_pass", 64'(bus.pass), 64'd1);
      cyc(0, 0, 0, 32'h0, 64'hF);
      chk("done_holds", 64'(bus.done), 64'd1);

      basic_run(64'hE);
      chk("wrong_exp_pass", 64'(bus.pass), 64'd0);

      // stall between 1st and 2nd sample
      cyc(0, 1, 0, 32'h0, 64'hF);
      cyc(0, 0, 0, 32'h0, 64'hF);
      cyc(0, 0, 0, 32'h0, 64'hF);
      cyc(0, 0, 1, 32'h5, 64'hF);
      cyc(0, 0, 0, 32'hA, 64'hF);
      chk("stall_hold1", bus.signature, 64'h5);
      cyc(0, 0, 0, 32'hA, 64'hF);
      chk("stall_hold2", bus.signature, 64'h5);
      cyc(0, 0, 1, 32'hA, 64'hF);
      cyc(0, 0, 1, 32'hF, 64'hF);
      chk("stall_done", 64'(bus.done), 64'd1);
      chk("stall_pass", 64'(bus.pass), 64'd1);

      // reset mid-accumulation
      cyc(0, 1, 0, 32'h0, 64'hF);
      cyc(0, 0, 0, 32'h0, 64'hF);
      cyc(0, 0, 0, 32'h0, 64'hF);
      cyc(0, 0, 1, 32'h5, 64'hF);
      cyc(1, 1, 1, 32'hA, 64'hF);
      chk("midreset_busy", 64'(bus.busy), 64'd0);
      chk("midreset_cnt", 64'(bus.sample_count), 64'd0);
      cyc(0, 0, 0, 32'h0, 64'hF);
      basic_run(64'hF);
      chk("rerun_pass", 64'(bus.pass), 64'd1);

      // start held high: one run only, then restart from DONE
      cyc(0, 1, 0, 32'h0, 64'hF);
      cyc(0, 1, 0, 32'h0, 64'hF);
      cyc(0, 1, 0, 32'h0, 64'hF);
      cyc(0, 1, 1, 32'h5, 64'hF);
      cyc(0, 1, 1, 32'hA, 64'hF);
      cyc(0, 1, 1, 32'hF, 64'hF);
      chk("held_done", 64'(bus.done), 64'd1);
      chk("held_sig", bus.signature, 64'hF);
      cyc(0, 1, 0, 32'h0, 64'hF);
      chk("restart_done", 64'(bus.done), 64'd0);
      chk("restart_busy", 64'(bus.busy), 64'd1);
      chk("restart_sig", bus.signature, 64'h0);
      cyc(0, 0, 0, 32'h0, 64'hF);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         d = $urandom;
         if ($urandom_range(0, 1) == 1)
            e = misr(m_sig, d);
         else
            e = {$urandom, $urandom};
         cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < 6, d, e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
